// File: rtl/stream_decomp_pkg.sv
// Shared code/state types and code-length helper for the stream decompressor.
package stream_decomp_pkg;

   typedef enum logic [1:0] {
      ZERO = 2'b00,
      LIT  = 2'b01,
      FULL = 2'b10,
      PART = 2'b11
   } code_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_DRAIN,
      S_HOLD
   } state_e;

   // Total code length in bits, including the 2-bit code.
   function automatic int unsigned code_len(input code_e code,
                                            input int unsigned idx_w,
                                            input int unsigned width);
      case (code)
         ZERO:    return 2;
         LIT:     return 2 + width;
         FULL:    return 2 + idx_w;
         default: return 2 + idx_w + width / 2;
      endcase
   endfunction

endpackage

// File: rtl/decomp_word_decoder.sv
// Decodes one code from the buffer head against a flat dictionary snapshot.
// Purely combinational, zero latency, no flow control of its own.
module decomp_word_decoder
   import stream_decomp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DICT_DEPTH = 16,
   parameter int IDX        = 4,
   parameter int MAX_LEN    = 34,
   parameter int LEN_W      = 8
) (
   input  logic [MAX_LEN-1:0]          code_i,
   input  logic [DICT_DEPTH*WIDTH-1:0] dict_i,
   input  logic [IDX:0]                count_i,
   output logic [LEN_W-1:0]            len_o,
   output logic [WIDTH-1:0]            word_o,
   output logic                        push_o,
   output logic                        err_o
);

   code_e            code;
   logic [IDX-1:0]   idx;
   logic [WIDTH-1:0] entry;
   logic             bad;

   assign code  = code_e'(code_i[1:0]);
   assign idx   = code_i[IDX+1:2];
   assign entry = dict_i[int'(idx)*WIDTH +: WIDTH];
   assign bad   = ({1'b0, idx} >= count_i);

   always_comb begin
      len_o  = LEN_W'(code_len(code, IDX, WIDTH));
      word_o = '0;
      push_o = 1'b0;
      err_o  = 1'b0;
      case (code)
         LIT: begin
            word_o = code_i[WIDTH+1:2];
            push_o = 1'b1;
         end
         FULL: begin
            err_o  = bad;
            word_o = bad ? '0 : entry;
         end
         PART: begin
            err_o  = bad;
            word_o = bad ? '0 : {entry[WIDTH-1:WIDTH/2], code_i[IDX+WIDTH/2+1:IDX+2]};
            push_o = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/stream_decompressor.sv
// Two-words-per-cycle line decompressor with FIFO dictionary; raw lines 1 cycle, compressed >= 1+WPL/2.
// o_ready comes from registered state only; a completed line waits in HOLD while the output is stalled.
module stream_decompressor
   import stream_decomp_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DICT_DEPTH = 16,
   parameter int LINE_WIDTH = 128,
   parameter int MAX_LEN    = WIDTH + 2,
   parameter int BUF_WIDTH  = LINE_WIDTH + 2 * MAX_LEN
) (
   input  logic                          i_clk,
   input  logic                          i_reset,
   input  logic                          i_valid,
   output logic                          o_ready,
   input  logic [LINE_WIDTH-1:0]         i_data,
   input  logic                          i_comp_flag,
   input  logic                          i_last,
   input  logic                          i_dict_clear,
   output logic                          o_valid,
   input  logic                          i_ready,
   output logic [LINE_WIDTH-1:0]         o_data,
   output logic                          o_err,
   output logic [$clog2(DICT_DEPTH):0]   o_dict_count
);

   localparam int IDX   = $clog2(DICT_DEPTH);
   localparam int WPL   = LINE_WIDTH / WIDTH;
   localparam int OCC_W = $clog2(BUF_WIDTH + 1);
   localparam int WC_W  = $clog2(WPL + 1);

   localparam logic [OCC_W-1:0] FILL_MAX  = OCC_W'(BUF_WIDTH - LINE_WIDTH);
   localparam logic [OCC_W-1:0] BEAT_BITS = OCC_W'(LINE_WIDTH);
   localparam logic [WC_W-1:0]  WPL_C     = WC_W'(WPL);
   localparam logic [WC_W-1:0]  WPL_M1    = WC_W'(WPL - 1);
   localparam logic [IDX:0]     DEPTH_C   = (IDX+1)'(DICT_DEPTH);
   localparam logic [IDX:0]     ONE_C     = (IDX+1)'(1);

   state_e                      state_q, state_d;
   logic [BUF_WIDTH-1:0]        buf_q, buf_d;
   logic [OCC_W-1:0]            occ_q, occ_d;
   logic [WC_W-1:0]             words_q, words_d;
   logic [LINE_WIDTH-1:0]       asm_q, asm_d;
   logic                        out_vld_q, out_vld_d;
   logic [LINE_WIDTH-1:0]       out_dat_q, out_dat_d;
   logic [DICT_DEPTH*WIDTH-1:0] dict_q, dict_d;
   logic [IDX:0]                cnt_q, cnt_d;
   logic                        err_q, err_d;

   logic [OCC_W-1:0]            len0, len1, consumed, occ_sh;
   logic [WIDTH-1:0]            word0, word1;
   logic                        push0, push1, err0, err1;
   logic                        decoding, dec0, dec1, done, accept, out_free;
   logic [MAX_LEN-1:0]          win1;
   logic [DICT_DEPTH*WIDTH-1:0] dict_fwd;
   logic [IDX:0]                cnt_fwd;
   logic [WC_W-1:0]             words_nx;
   logic [LINE_WIDTH-1:0]       asm_nx;
   logic [BUF_WIDTH-1:0]        beat_ext;

   assign o_ready  = (state_q == S_IDLE) || (state_q == S_FILL && occ_q <= FILL_MAX);
   assign accept   = i_valid && o_ready;
   assign out_free = !out_vld_q || i_ready;
   assign beat_ext = {{(BUF_WIDTH-LINE_WIDTH){1'b0}}, i_data};

   decomp_word_decoder #(
      .WIDTH(WIDTH), .DICT_DEPTH(DICT_DEPTH), .IDX(IDX), .MAX_LEN(MAX_LEN), .LEN_W(OCC_W)
   ) u_slot0 (
      .code_i(buf_q[MAX_LEN-1:0]), .dict_i(dict_q), .count_i(cnt_q),
      .len_o(len0), .word_o(word0), .push_o(push0), .err_o(err0)
   );

   // Slot 1 sees the dictionary with slot 0's push already applied.
   assign win1     = MAX_LEN'(buf_q >> len0);
   assign dict_fwd = (dec0 && push0) ? {dict_q[(DICT_DEPTH-1)*WIDTH-1:0], word0} : dict_q;
   assign cnt_fwd  = (dec0 && push0 && cnt_q != DEPTH_C) ? cnt_q + ONE_C : cnt_q;

   decomp_word_decoder #(
      .WIDTH(WIDTH), .DICT_DEPTH(DICT_DEPTH), .IDX(IDX), .MAX_LEN(MAX_LEN), .LEN_W(OCC_W)
   ) u_slot1 (
      .code_i(win1), .dict_i(dict_fwd), .count_i(cnt_fwd),
      .len_o(len1), .word_o(word1), .push_o(push1), .err_o(err1)
   );

   assign decoding = (state_q == S_FILL) || (state_q == S_DRAIN);
   assign dec0     = decoding && (words_q < WPL_C) && (occ_q >= len0);
   assign dec1     = dec0 && (words_q < WPL_M1) && (occ_q >= len0 + len1);
   assign consumed = (dec0 ? len0 : '0) + (dec1 ? len1 : '0);
   assign occ_sh   = occ_q - consumed;
   assign words_nx = words_q + WC_W'(dec0) + WC_W'(dec1);
   assign done     = decoding && (words_nx == WPL_C);

   always_comb begin
      asm_nx = asm_q;
      if (dec0) asm_nx[int'(words_q)*WIDTH +: WIDTH] = word0;
      if (dec1) asm_nx[(int'(words_q)+1)*WIDTH +: WIDTH] = word1;
   end

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      occ_d     = occ_q;
      words_d   = words_q;
      asm_d     = asm_q;
      out_vld_d = out_vld_q && !i_ready;
      out_dat_d = out_dat_q;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (i_comp_flag) begin
                  buf_d   = beat_ext;
                  occ_d   = BEAT_BITS;
                  words_d = '0;
                  state_d = i_last ? S_DRAIN : S_FILL;
               end else if (out_free) begin
                  out_vld_d = 1'b1;
                  out_dat_d = i_data;
               end else begin
                  asm_d   = i_data;
                  state_d = S_HOLD;
               end
            end
         end
         S_FILL, S_DRAIN: begin
            // Bits left after the last word of a line are padding.
            if (done) begin
               buf_d   = '0;
               occ_d   = '0;
               words_d = '0;
               if (out_free) begin
                  out_vld_d = 1'b1;
                  out_dat_d = asm_nx;
                  state_d   = S_IDLE;
               end else begin
                  asm_d   = asm_nx;
                  state_d = S_HOLD;
               end
            end else begin
               asm_d   = asm_nx;
               words_d = words_nx;
               buf_d   = buf_q >> consumed;
               occ_d   = occ_sh;
               if (accept) begin
                  buf_d = buf_d | (beat_ext << occ_sh);
                  occ_d = occ_sh + BEAT_BITS;
                  if (i_last) state_d = S_DRAIN;
               end
            end
         end
         S_HOLD: begin
            if (out_free) begin
               out_vld_d = 1'b1;
               out_dat_d = asm_q;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      dict_d = dict_fwd;
      cnt_d  = cnt_fwd;
      err_d  = err_q || (dec0 && err0) || (dec1 && err1);
      if (dec1 && push1) begin
         dict_d = {dict_fwd[(DICT_DEPTH-1)*WIDTH-1:0], word1};
         cnt_d  = (cnt_fwd == DEPTH_C) ? cnt_fwd : cnt_fwd + ONE_C;
      end
      if (i_dict_clear) begin
         dict_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state_q   <= S_IDLE;
         buf_q     <= '0;
         occ_q     <= '0;
         words_q   <= '0;
         asm_q     <= '0;
         out_vld_q <= 1'b0;
         out_dat_q <= '0;
         dict_q    <= '0;
         cnt_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         buf_q     <= buf_d;
         occ_q     <= occ_d;
         words_q   <= words_d;
         asm_q     <= asm_d;
         out_vld_q <= out_vld_d;
         out_dat_q <= out_dat_d;
         dict_q    <= dict_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
      end
   end

   assign o_valid      = out_vld_q;
   assign o_data       = out_dat_q;
   assign o_err        = err_q;
   assign o_dict_count = cnt_q;

endmodule

// File: tb/tb_stream_decompressor.sv
// Directed bench for stream_decompressor: hand-encoded lines, expected words computed by hand.
module tb_stream_decompressor;

   logic         i_clk = 1'b0;
   logic         i_reset;
   logic         i_valid;
   logic         o_ready;
   logic [127:0] i_data;
   logic         i_comp_flag;
   logic         i_last;
   logic         i_dict_clear;
   logic         o_valid;
   logic         i_ready;
   logic [127:0] o_data;
   logic         o_err;
   logic [4:0]   o_dict_count;

   int errors = 0;
   int checks = 0;
   int lat;

   logic [255:0] sbits;
   int           spos;

   always #5 i_clk = ~i_clk;

   stream_decompressor dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
      .i_data(i_data), .i_comp_flag(i_comp_flag), .i_last(i_last),
      .i_dict_clear(i_dict_clear), .o_valid(o_valid), .i_ready(i_ready),
      .o_data(o_data), .o_err(o_err), .o_dict_count(o_dict_count)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic new_stream();
      sbits = '0;
      spos  = 0;
   endtask

   task automatic put(input logic [31:0] v, input int n);
      for (int i = 0; i < n; i++) begin
         sbits[spos] = v[i];
         spos++;
      end
   endtask

   task automatic c_zero();
      put(32'd0, 2);
   endtask

   task automatic c_lit(input logic [31:0] d);
      put(32'd1, 2);
      put(d, 32);
   endtask

   task automatic c_full(input logic [3:0] idx);
      put(32'd2, 2);
      put({28'd0, idx}, 4);
   endtask

   task automatic c_part(input logic [3:0] idx, input logic [15:0] lo);
      put(32'd3, 2);
      put({28'd0, idx}, 4);
      put({16'd0, lo}, 16);
   endtask

   // Returns 1 ns after the edge that accepted the beat.
   task automatic send(input logic [127:0] d, input logic comp, input logic last);
      int n;
      @(negedge i_clk);
      i_valid     = 1'b1;
      i_data      = d;
      i_comp_flag = comp;
      i_last      = last;
      n = 0;
      while (!o_ready && n < 40) begin
         @(negedge i_clk);
         n++;
      end
      @(posedge i_clk);
      #1;
      i_valid     = 1'b0;
      i_comp_flag = 1'b0;
      i_last      = 1'b0;
   endtask

   // Latency counted from the beat's presentation cycle (the acceptance cycle is 1).
   task automatic wait_out(output int l);
      l = 1;
      while (!o_valid && l < 40) begin
         @(posedge i_clk);
         #1;
         l++;
      end
   endtask

   initial begin
      i_reset      = 1'b0;
      i_valid      = 1'b0;
      i_data       = '0;
      i_comp_flag  = 1'b0;
      i_last       = 1'b0;
      i_dict_clear = 1'b0;
      i_ready      = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      chk("rst_valid", 128'(o_valid), 128'(0));
      chk("rst_data",  o_data, 128'(0));
      chk("rst_err",   128'(o_err), 128'(0));
      chk("rst_count", 128'(o_dict_count), 128'(0));
      chk("rst_ready", 128'(o_ready), 128'(1));
      @(negedge i_clk);
      i_reset = 1'b1;

      // All-zero line
      send(128'h0, 1'b1, 1'b1);
      wait_out(lat);
      chk("zero_lat",   128'(lat), 128'(3));
      chk("zero_data",  o_data, 128'(0));
      chk("zero_count", 128'(o_dict_count), 128'(0));
      @(posedge i_clk);
      #1;
      chk("zero_taken", 128'(o_valid), 128'(0));

      // Forwarding: slot 1 full-matches the literal slot 0 pushes
      new_stream();
      c_lit(32'h12345678); c_full(4'd0); c_zero(); c_zero();
      send(sbits[127:0], 1'b1, 1'b1);
      wait_out(lat);
      chk("fwd_lat",   128'(lat), 128'(3));
      chk("fwd_data",  o_data, {32'h0, 32'h0, 32'h12345678, 32'h12345678});
      chk("fwd_count", 128'(o_dict_count), 128'(1));
      chk("fwd_err",   128'(o_err), 128'(0));

      // Raw pass-through
      send({16{8'hA5}}, 1'b0, 1'b0);
      wait_out(lat);
      chk("raw_lat",   128'(lat), 128'(1));
      chk("raw_data",  o_data, {16{8'hA5}});
      chk("raw_count", 128'(o_dict_count), 128'(1));

      // Four literals over two beats (136 bits)
      new_stream();
      c_lit(32'h11111111); c_lit(32'h22222222); c_lit(32'hCAFE1234); c_lit(32'h44444444);
      send(sbits[127:0], 1'b1, 1'b0);
      send(sbits[255:128], 1'b1, 1'b1);
      wait_out(lat);
      chk("multi_data",  o_data, {32'h44444444, 32'hCAFE1234, 32'h22222222, 32'h11111111});
      chk("multi_count", 128'(o_dict_count), 128'(5));

      // Partial match against idx 1 = 0xCAFE1234
      new_stream();
      c_part(4'd1, 16'hBEEF); c_zero(); c_zero(); c_zero();
      send(sbits[127:0], 1'b1, 1'b1);
      wait_out(lat);
      chk("part_data",  o_data, {32'h0, 32'h0, 32'h0, 32'hCAFEBEEF});
      chk("part_count", 128'(o_dict_count), 128'(6));

      @(negedge i_clk);
      i_dict_clear = 1'b1;
      @(negedge i_clk);
      i_dict_clear = 1'b0;
      chk("clear_count", 128'(o_dict_count), 128'(0));

      // Backpressure: line C parked in the output, line D waits in HOLD
      i_ready = 1'b0;
      new_stream();
      c_lit(32'hDEADBEEF); c_lit(32'h0BADF00D); c_zero(); c_zero();
      send(sbits[127:0], 1'b1, 1'b1);
      wait_out(lat);
      chk("bp_c_valid", 128'(o_valid), 128'(1));
      new_stream();
      c_full(4'd5); c_lit(32'h77777777); c_zero(); c_zero();
      send(sbits[127:0], 1'b1, 1'b1);
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clk);
         chk("bp_c_stable", o_data, {32'h0, 32'h0, 32'h0BADF00D, 32'hDEADBEEF});
      end
      chk("bp_valid_held", 128'(o_valid), 128'(1));
      chk("bp_ready_low",  128'(o_ready), 128'(0));
      chk("bad_idx_err",   128'(o_err), 128'(1));
      chk("bp_count",      128'(o_dict_count), 128'(3));
      i_ready = 1'b1;
      @(posedge i_clk);
      #1;
      chk("bp_d_valid", 128'(o_valid), 128'(1));
      chk("bp_d_data",  o_data, {32'h0, 32'h0, 32'h77777777, 32'h0});
      @(posedge i_clk);
      #1;
      chk("bp_drained", 128'(o_valid), 128'(0));
      chk("bp_ready",   128'(o_ready), 128'(1));

      // Reset while the next line is in DRAIN
      new_stream();
      c_lit(32'h13579BDF); c_zero(); c_zero(); c_zero();
      send(sbits[127:0], 1'b1, 1'b1);
      #2;
      i_reset = 1'b0;
      #1;
      chk("mid_rst_valid", 128'(o_valid), 128'(0));
      chk("mid_rst_data",  o_data, 128'(0));
      chk("mid_rst_err",   128'(o_err), 128'(0));
      chk("mid_rst_count", 128'(o_dict_count), 128'(0));
      chk("mid_rst_ready", 128'(o_ready), 128'(1));
      @(negedge i_clk);
      i_reset = 1'b1;

      new_stream();
      c_lit(32'h600DCAFE); c_full(4'd0); c_zero(); c_zero();
      send(sbits[127:0], 1'b1, 1'b1);
      wait_out(lat);
      chk("post_rst_lat",   128'(lat), 128'(3));
      chk("post_rst_data",  o_data, {32'h0, 32'h0, 32'h600DCAFE, 32'h600DCAFE});
      chk("post_rst_count", 128'(o_dict_count), 128'(1));
      chk("post_rst_err",   128'(o_err), 128'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
